uart_xcvr: RTL
==============

# uart_xcvr

Parametrised full-duplex UART transceiver: next generation of the fixed-role `uart` block, merging writer and reader roles into one instance with configurable data width, bit period and stop bits. Parallel side uses valid/ready on transmit and a one-cycle valid pulse on receive; serial side is a standard idle-high line, LSB first. Sits between any byte-producing core and the board pins; two instances cross-connected (`tx`→`rx`) form the standard loopback bench.

## Interface
- `DATA_W`, 8: payload bits per frame, 5..9.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit, even, ≥4.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  single clock, rising edge; all logic in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_W  word to send, sampled on handshake.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmitter idle, accepts word.
- `rx_data`  out  DATA_W  last received word, held until next valid frame.
- `rx_valid`  out  1  one-cycle pulse: new `rx_data`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without parity).
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output, idle high.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE. Each bit state lasts exactly `CLKS_PER_BIT` cycles; bit counter wraps DATA_W-1 → 0 on exit from DATA; STOP lasts `STOP_BITS*CLKS_PER_BIT`.
- Handshake: transfer when `tx_valid && tx_ready` on a rising edge; `tx_data` latched into shift register; `tx_ready` low from next cycle until return to IDLE. `tx_valid` without `tx_ready` is ignored; no queue.
- RX: `rx` passes a two-flop synchroniser. FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: synchronised `rx`=0 enters START, counter loaded for `CLKS_PER_BIT/2`. At mid-start, line high → glitch, return to IDLE silently; low → sample each further bit at its centre (`CLKS_PER_BIT` apart), LSB first.
- STOP: only first stop bit sampled. High → `rx_data` updated, `rx_valid` pulses. Low → `rx_frame_err` pulses, `rx_data` unchanged, no `rx_valid`; FSM waits for line high before IDLE (break condition never re-triggers).
- No receive backpressure: consumer must take `rx_data` before next `rx_valid`.
- Reset mid-frame: both FSMs to IDLE next edge, partial frame discarded, no pulses emitted, `tx` high immediately.

## Timing
- Handshake at edge N → `tx` falls at N+1; frame occupies `(1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT` cycles, P=1 with parity; `tx_ready` high in the cycle after last stop cycle; back-to-back words give gap-free frames when `tx_valid` held.
- RX: `rx_valid`/error pulse one cycle after the mid-stop sample, i.e. `2 + (1+DATA_W+P)*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1` cycles after the start-bit falling edge at pin (±1 for synchroniser phase).
- Tolerates ±4% bit-rate mismatch at `CLKS_PER_BIT`=16.

## Configuration
- `UART_PARITY_EN` defined: PARITY state present in both FSMs; even parity over data bits; mismatch pulses `rx_parity_err` alongside `rx_valid` (word still delivered).
- Undefined: no parity bit on line, `rx_parity_err` tied 0, frame is start+data+stop.

## Structure
- Package `uart_pkg`: TX/RX state enums, `uart_parity_bit` function (XOR reduce), localparam for counter width `$clog2(CLKS_PER_BIT*2)`.
- One sub-module: `uart_rx` (synchroniser, receive FSM, error flags); transmitter stays inline in `uart_xcvr`.

## Test plan
- Loopback (two instances, `CLKS_PER_BIT`=4, DATA_W=8): send 8'hC3, then 8'h3C, then "c" (8'h63) → each `rx_data` matches, one `rx_valid` per word, no errors.
- Back-to-back: hold `tx_valid`, words 8'h00, 8'hFF → `tx` never idles between frames; `tx_ready` high one cycle per word; both received in order.
- Glitch: drive `rx` low for 1 cycle at `CLKS_PER_BIT`=16 → no `rx_valid`, RX returns to IDLE.
- Framing error: inject frame 8'hA5 with stop bit low → `rx_frame_err` pulse, `rx_data` keeps previous value, next good frame 8'h5A received.
- `UART_PARITY_EN`: send 8'h07 with parity bit flipped → `rx_valid` and `rx_parity_err` same cycle, `rx_data`=8'h07.
- Reset mid-frame during DATA bit 3 → `tx`=1 next edge, `tx_ready`=1, receiver emits no pulse; subsequent 8'h81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encodings and helpers for the uart_xcvr transceiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_MAX_DATA_W = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Bit-period counter width; wide enough for a two-stop-bit countdown.
    function automatic int uart_cnt_w(input int clks_per_bit);
        return $clog2(clks_per_bit * 2);
    endfunction

    // Even parity: zero-extension of narrower words leaves the result unchanged.
    function automatic logic uart_parity_bit(input logic [c_MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver: two-flop synchroniser, mid-bit sampling FSM,
//            framing/parity error pulses. Parity bit present when
//            UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    localparam int c_CNT_W = uart_cnt_w(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST = c_BIT_W'(DATA_W - 1);

    rx_state_t          r_state;
    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_BIT_W-1:0] r_bit;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_ferr;
`ifdef UART_PARITY_EN
    logic               r_par;
    logic               r_perr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_meta  <= rx;
            r_sync  <= r_meta;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    if (!r_sync) begin
                        r_state <= RX_START;
                        r_cnt   <= c_HALF;
                    end
                end
                RX_START: begin
                    if (r_cnt == '0) begin
                        // A start bit that has gone high by its centre was noise.
                        if (r_sync) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_state <= RX_DATA;
                            r_cnt   <= c_FULL;
                            r_bit   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {r_sync, r_shift[DATA_W-1:1]};
                        r_cnt   <= c_FULL;
                        if (r_bit == c_LAST) begin
                            r_bit <= '0;
`ifdef UART_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + c_BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (r_cnt == '0) begin
                        r_par   <= r_sync;
                        r_cnt   <= c_FULL;
                        r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_sync) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
`ifdef UART_PARITY_EN
                            r_perr  <= uart_parity_bit(c_MAX_DATA_W'(r_shift)) ^ r_par;
`endif
                            r_state <= RX_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= RX_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                // Hold off until the line recovers so a break is reported once.
                RX_BREAK: begin
                    if (r_sync) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_ferr;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_perr;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr
// Brief    : Full-duplex UART transceiver, valid/ready transmit, pulsed
//            receive. Define UART_PARITY_EN to add an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_parity_err,
    input  logic              rx,
    output logic              tx
);

    localparam int c_CNT_W = uart_cnt_w(CLKS_PER_BIT);
    localparam int c_BIT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_STOP = c_CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0] c_LAST = c_BIT_W'(DATA_W - 1);

    tx_state_t          r_tx_state;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic [c_BIT_W-1:0] r_tx_bit;
    logic [DATA_W-1:0]  r_tx_shift;
    logic               r_tx;
    logic               r_tx_ready;
`ifdef UART_PARITY_EN
    logic               r_tx_par;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        r_tx_shift <= tx_data;
`ifdef UART_PARITY_EN
                        r_tx_par   <= uart_parity_bit(c_MAX_DATA_W'(tx_data));
`endif
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_cnt   <= c_FULL;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == '0) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_cnt   <= c_FULL;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - c_CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == '0) begin
                        if (r_tx_bit == c_LAST) begin
                            r_tx_bit <= '0;
`ifdef UART_PARITY_EN
                            r_tx       <= r_tx_par;
                            r_tx_cnt   <= c_FULL;
                            r_tx_state <= TX_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_tx_cnt   <= c_STOP;
                            r_tx_state <= TX_STOP;
`endif
                        end else begin
                            // Shift first, drive the next bit straight from bit 1.
                            r_tx_bit   <= r_tx_bit + c_BIT_W'(1);
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx       <= r_tx_shift[1];
                            r_tx_cnt   <= c_FULL;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - c_CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (r_tx_cnt == '0) begin
                        r_tx       <= 1'b1;
                        r_tx_cnt   <= c_STOP;
                        r_tx_state <= TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - c_CNT_W'(1);
                    end
                end
`endif
                TX_STOP: begin
                    if (r_tx_cnt == '0) begin
                        r_tx_ready <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;

    uart_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

endmodule
`default_nettype wire
